// File: rtl/fetch_unit.sv
// ---------------------------------------------------------------------------
// fetch_unit
//   IF stage of the 5-stage RV32I pipeline. Owns the fetch PC, issues
//   word-aligned requests to instruction memory over a valid/ready channel,
//   buffers the in-order responses in a small FIFO and presents one
//   {pc, instr} pair per cycle to the IF/ID register. A taken branch/jump
//   from EX redirects the PC, clears the FIFO and discards every response
//   that was still in flight.
//
// Ports
//   clk, rst          clock; synchronous active-high reset
//   stall_f           hazard unit: hold the presented pair, do not pop
//   e_b_taken         redirect request from EX this cycle
//   e_b_target        redirect PC (low two bits ignored)
//   imem_req_valid    request valid
//   imem_req_addr     fetch address (word aligned)
//   imem_req_ready    memory accepts the request
//   imem_rsp_valid    in-order response valid (latency >= 1 cycle)
//   imem_rsp_data     instruction word of the response
//   f_valid           f_instr/f_pc carry a real instruction
//   f_instr           instruction to decode (NOP_INSTR when f_valid=0)
//   f_pc              PC of f_instr (holds its last value when empty)
//   f_pc_plus4        f_pc + 4 for JAL/JALR link values
// ---------------------------------------------------------------------------
module fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int          DEPTH     = 2,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall_f,
    input  logic        e_b_taken,
    input  logic [31:0] e_b_target,
    output logic        imem_req_valid,
    output logic [31:0] imem_req_addr,
    input  logic        imem_req_ready,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    output logic        f_valid,
    output logic [31:0] f_instr,
    output logic [31:0] f_pc,
    output logic [31:0] f_pc_plus4
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [CNT_W:0] DEPTH_C = (CNT_W + 1)'(DEPTH);

    logic [31:0]      fetch_pc;
    logic [CNT_W-1:0] outstanding;
    logic [CNT_W-1:0] outstanding_next;
    logic [CNT_W-1:0] drop_cnt;
    logic [CNT_W-1:0] drop_cnt_next;
    logic [CNT_W-1:0] count;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] tag_rd;
    logic [PTR_W-1:0] tag_wr;
    logic [31:0]      last_pc;

    logic [31:0] pc_mem    [DEPTH];
    logic [31:0] instr_mem [DEPTH];
    logic [31:0] tag_mem   [DEPTH];

    logic           empty;
    logic           pop;
    logic           push;
    logic           accept;
    logic           dropping;
    logic [CNT_W:0] credit_used;

    assign empty    = (count == '0);
    assign f_valid  = !empty;
    assign pop      = f_valid && !stall_f && !e_b_taken;
    assign dropping = (drop_cnt != '0);

    // Credits are counted after this cycle's pop: the slot being drained
    // now is free by the time the new request's response can arrive
    // (latency >= 1), which is what lets a DEPTH=2 FIFO sustain one
    // instruction per cycle against a 1-cycle memory.
    assign credit_used = {1'b0, outstanding} + {1'b0, count} - (CNT_W + 1)'(pop);

    assign imem_req_valid = !rst && (credit_used < DEPTH_C);
    assign imem_req_addr  = fetch_pc;
    assign accept         = imem_req_valid && imem_req_ready;

    // A response is kept only if it is not stale and no redirect is
    // happening in the same cycle.
    assign push = imem_rsp_valid && !dropping && !e_b_taken;

    assign f_instr    = empty ? NOP_INSTR : instr_mem[rd_ptr];
    assign f_pc       = empty ? last_pc   : pc_mem[rd_ptr];
    assign f_pc_plus4 = f_pc + 32'd4;

    // On a redirect every request still owed by memory after this cycle,
    // including one accepted this very cycle, becomes stale.
    always_comb begin
        outstanding_next = outstanding + CNT_W'(accept) - CNT_W'(imem_rsp_valid);
        drop_cnt_next    = drop_cnt;
        if (e_b_taken) begin
            drop_cnt_next = outstanding_next;
        end else if (imem_rsp_valid && dropping) begin
            drop_cnt_next = drop_cnt - CNT_W'(1);
        end
    end

    // Control state: PC, credit counters, FIFO and tag-FIFO pointers.
    // The tag FIFO is never cleared by a redirect; stale responses still
    // pop their tag so the tags stay aligned with the response stream.
    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc    <= RESET_PC;
            outstanding <= '0;
            drop_cnt    <= '0;
            count       <= '0;
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            tag_rd      <= '0;
            tag_wr      <= '0;
            last_pc     <= '0;
        end else begin
            outstanding <= outstanding_next;
            drop_cnt    <= drop_cnt_next;

            if (e_b_taken) begin
                fetch_pc <= {e_b_target[31:2], 2'b00};
            end else if (accept) begin
                fetch_pc <= fetch_pc + 32'd4;
            end

            if (accept) begin
                tag_wr <= tag_wr + PTR_W'(1);
            end
            if (imem_rsp_valid) begin
                tag_rd <= tag_rd + PTR_W'(1);
            end

            if (!empty) begin
                last_pc <= pc_mem[rd_ptr];
            end

            if (e_b_taken) begin
                count  <= '0;
                rd_ptr <= '0;
                wr_ptr <= '0;
            end else begin
                count <= count + CNT_W'(push) - CNT_W'(pop);
                if (push) begin
                    wr_ptr <= wr_ptr + PTR_W'(1);
                end
                if (pop) begin
                    rd_ptr <= rd_ptr + PTR_W'(1);
                end
            end
        end
    end

    // Storage arrays carry no reset; validity is tracked by the pointers.
    always_ff @(posedge clk) begin
        if (accept) begin
            tag_mem[tag_wr] <= fetch_pc;
        end
        if (push && !rst) begin
            pc_mem[wr_ptr]    <= tag_mem[tag_rd];
            instr_mem[wr_ptr] <= imem_rsp_data;
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// ---------------------------------------------------------------------------
// tb_fetch_unit
//   Bench for fetch_unit. A behavioural instruction memory (in-order queue
//   with configurable latency) answers requests with a fixed hash of the
//   address. A program-order model tracks the PC that decode should see
//   next and the address the fetch side should request next; directed
//   scenarios are followed by a randomized run.
// ---------------------------------------------------------------------------
module tb_fetch_unit;

    localparam logic [31:0] RESET_PC  = 32'h0000_0000;
    localparam int          DEPTH     = 2;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    logic        clk;
    logic        rst;
    logic        stall_f;
    logic        e_b_taken;
    logic [31:0] e_b_target;
    logic        imem_req_valid;
    logic [31:0] imem_req_addr;
    logic        imem_req_ready;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        f_valid;
    logic [31:0] f_instr;
    logic [31:0] f_pc;
    logic [31:0] f_pc_plus4;

    fetch_unit #(
        .RESET_PC (RESET_PC),
        .DEPTH    (DEPTH),
        .NOP_INSTR(NOP_INSTR)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .stall_f       (stall_f),
        .e_b_taken     (e_b_taken),
        .e_b_target    (e_b_target),
        .imem_req_valid(imem_req_valid),
        .imem_req_addr (imem_req_addr),
        .imem_req_ready(imem_req_ready),
        .imem_rsp_valid(imem_rsp_valid),
        .imem_rsp_data (imem_rsp_data),
        .f_valid       (f_valid),
        .f_instr       (f_instr),
        .f_pc          (f_pc),
        .f_pc_plus4    (f_pc_plus4)
    );

    // Free-running clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        int          due;
    } memReq_t;

    memReq_t     memQ[$];
    int          cyc;
    int          lastDue;
    int          latMin;
    int          latMax;
    int          checks;
    int          failures;
    int          consumed;
    logic [31:0] expPc;
    logic [31:0] expFetch;
    logic [31:0] lastShown;

    logic        sValid;
    logic [31:0] sInstr;
    logic [31:0] sPc;
    logic [31:0] sPc4;
    logic        sReqValid;
    logic [31:0] sAddr;

    // Contents of instruction memory: a fixed scramble of the address
    function automatic logic [31:0] memFn(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0000;
    endfunction

    // Single comparison point: counts and reports mismatches
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            failures++;
            $display("[TB] FAIL %s observed=%h expected=%h cycle=%0d",
                     tag, observed, expected, cyc);
        end
    endtask

    // Program-order model: a valid head must always be the next instruction
    // of the program, and the request address the next one to fetch
    task automatic scoreboardCycle(input logic stall, input logic taken,
                                   input logic [31:0] target, input logic ready,
                                   input int outStart);
        if (sValid) begin
            checkOutput("sb_pc", sPc, expPc);
            checkOutput("sb_instr", sInstr, memFn(sPc));
            checkOutput("sb_pc4", sPc4, sPc + 32'd4);
            lastShown = sPc;
            if (!stall && !taken) begin
                expPc = expPc + 32'd4;
                consumed++;
            end
        end else begin
            checkOutput("sb_nop", sInstr, NOP_INSTR);
            checkOutput("sb_hold_pc", sPc, lastShown);
            checkOutput("sb_hold_pc4", sPc4, lastShown + 32'd4);
        end
        if (taken) begin
            expPc = target & ~32'd3;
        end
        if (sReqValid) begin
            checkOutput("sb_addr", sAddr, expFetch);
        end
        if (outStart >= DEPTH) begin
            checkOutput("sb_credit", 32'(sReqValid), 32'd0);
        end
        if (taken) begin
            expFetch = target & ~32'd3;
        end else if (sReqValid && ready) begin
            expFetch = expFetch + 32'd4;
        end
    endtask

    // One clock cycle: drive inputs and the memory response, sample at the
    // falling edge, run the model, record an accepted request
    task automatic applyStimulus(input logic stall, input logic taken,
                                 input logic [31:0] target, input logic ready);
        int outStart;
        int d;
        stall_f        = stall;
        e_b_taken      = taken;
        e_b_target     = target;
        imem_req_ready = ready;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = '0;
        outStart       = memQ.size();
        if (!rst && memQ.size() > 0 && memQ[0].due <= cyc) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = memFn(memQ[0].addr);
            void'(memQ.pop_front());
        end
        @(negedge clk);
        sValid    = f_valid;
        sInstr    = f_instr;
        sPc       = f_pc;
        sPc4      = f_pc_plus4;
        sReqValid = imem_req_valid;
        sAddr     = imem_req_addr;
        if (rst) begin
            checkOutput("rst_req_valid", 32'(sReqValid), 32'd0);
        end else begin
            scoreboardCycle(stall, taken, target, ready, outStart);
            if (sReqValid && ready) begin
                d = cyc + $urandom_range(latMin, latMax);
                if (d < lastDue) d = lastDue;
                memQ.push_back('{addr: sAddr, due: d});
                lastDue = d;
            end
        end
        @(posedge clk);
        cyc++;
        #1;
    endtask

    // Reset both DUT and memory model together
    task automatic doReset();
        rst = 1'b1;
        memQ.delete();
        lastDue = 0;
        applyStimulus(1'b0, 1'b0, 32'd0, 1'b1);
        applyStimulus(1'b0, 1'b0, 32'd0, 1'b1);
        rst       = 1'b0;
        expPc     = RESET_PC;
        expFetch  = RESET_PC;
        lastShown = 32'd0;
    endtask

    task automatic idle();
        applyStimulus(1'b0, 1'b0, 32'd0, 1'b1);
    endtask

    // Directed scenarios followed by a randomized run
    initial begin
        int waited;
        logic rs;
        logic rt;
        logic rr;
        logic [31:0] tgt;

        checks = 0; failures = 0; consumed = 0; cyc = 0;
        rst = 1'b1; stall_f = 0; e_b_taken = 0; e_b_target = '0;
        imem_req_ready = 0; imem_rsp_valid = 0; imem_rsp_data = '0;
        latMin = 1; latMax = 1;
        @(posedge clk); #1;

        // Reset release, 1-cycle memory, zero-bubble stream
        doReset();
        idle();
        checkOutput("t1_req0_valid", 32'(sReqValid), 32'd1);
        checkOutput("t1_req0_addr", sAddr, 32'h0);
        checkOutput("t1_rst_valid", 32'(sValid), 32'd0);
        checkOutput("t1_rst_instr", sInstr, NOP_INSTR);
        checkOutput("t1_rst_pc", sPc, 32'h0);
        checkOutput("t1_rst_pc4", sPc4, 32'h4);
        idle();
        checkOutput("t1_req1_addr", sAddr, 32'h4);
        checkOutput("t1_req1_valid", 32'(sReqValid), 32'd1);
        checkOutput("t1_no_valid_yet", 32'(sValid), 32'd0);
        idle();
        checkOutput("t1_req2_addr", sAddr, 32'h8);
        checkOutput("t1_req2_valid", 32'(sReqValid), 32'd1);
        checkOutput("t1_valid0", 32'(sValid), 32'd1);
        checkOutput("t1_pc0", sPc, 32'h0);
        checkOutput("t1_pc4_0", sPc4, 32'h4);
        idle();
        checkOutput("t1_valid1", 32'(sValid), 32'd1);
        checkOutput("t1_pc1", sPc, 32'h4);
        checkOutput("t1_pc4_1", sPc4, 32'h8);
        idle();
        checkOutput("t1_valid2", 32'(sValid), 32'd1);
        checkOutput("t1_pc2", sPc, 32'h8);
        checkOutput("t1_pc4_2", sPc4, 32'hC);

        // stall_f held three cycles on PC 0x4
        doReset();
        idle(); idle(); idle();
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 1'b0, 32'd0, 1'b1);
            checkOutput("t2_hold_valid", 32'(sValid), 32'd1);
            checkOutput("t2_hold_pc", sPc, 32'h4);
            if (i > 0) checkOutput("t2_no_credit", 32'(sReqValid), 32'd0);
        end
        idle();
        checkOutput("t2_resume_pc", sPc, 32'h4);
        checkOutput("t2_resume_addr", sAddr, 32'hC);
        idle();
        checkOutput("t2_next_pc", sPc, 32'h8);
        idle();
        checkOutput("t2_next2_pc", sPc, 32'hC);

        // Redirect to 0x103 with two requests in flight (3-cycle memory)
        latMin = 3; latMax = 3;
        doReset();
        idle(); idle();
        applyStimulus(1'b0, 1'b1, 32'h103, 1'b1);
        checkOutput("t3_full_credit", 32'(sReqValid), 32'd0);
        idle();
        checkOutput("t3_empty_after", 32'(sValid), 32'd0);
        checkOutput("t3_new_addr", sAddr, 32'h100);
        waited = 0;
        while (!sValid && waited < 12) begin
            idle();
            waited++;
        end
        checkOutput("t3_timeout", 32'(sValid), 32'd1);
        checkOutput("t3_pc", sPc, 32'h100);
        checkOutput("t3_instr", sInstr, memFn(32'h100));
        checkOutput("t3_pc4", sPc4, 32'h104);

        // imem_req_ready low for four cycles, redirect during the stall
        latMin = 1; latMax = 1;
        doReset();
        idle(); idle();
        for (int i = 0; i < 4; i++) begin
            if (i < 3) applyStimulus(1'b0, 1'b0, 32'd0, 1'b0);
            else       applyStimulus(1'b0, 1'b1, 32'h200, 1'b0);
            checkOutput("t4_addr_stable", sAddr, 32'h8);
            checkOutput("t4_req_valid", 32'(sReqValid), 32'd1);
            if (i >= 2) begin
                checkOutput("t4_gap_valid", 32'(sValid), 32'd0);
                checkOutput("t4_gap_instr", sInstr, NOP_INSTR);
                checkOutput("t4_gap_pc", sPc, 32'h4);
            end
        end
        idle();
        checkOutput("t4_redir_addr", sAddr, 32'h200);
        idle(); idle();
        checkOutput("t4_redir_valid", 32'(sValid), 32'd1);
        checkOutput("t4_redir_pc", sPc, 32'h200);

        // Reset while the FIFO is full
        doReset();
        idle(); idle();
        applyStimulus(1'b1, 1'b0, 32'd0, 1'b1);
        applyStimulus(1'b1, 1'b0, 32'd0, 1'b1);
        checkOutput("t6_full_credit", 32'(sReqValid), 32'd0);
        doReset();
        idle();
        checkOutput("t6_valid", 32'(sValid), 32'd0);
        checkOutput("t6_instr", sInstr, NOP_INSTR);
        checkOutput("t6_addr", sAddr, RESET_PC);
        checkOutput("t6_req_valid", 32'(sReqValid), 32'd1);
        checkOutput("t6_pc", sPc, 32'h0);

        // Randomized latency, stalls, back-pressure and redirects
        latMin = 1; latMax = 5;
        doReset();
        consumed = 0;
        for (int i = 0; i < 3000; i++) begin
            rs  = ($urandom_range(0, 3) == 0);
            rt  = ($urandom_range(0, 11) == 0);
            rr  = ($urandom_range(0, 3) != 0);
            tgt = $urandom & 32'h0000_0FFF;
            if ($urandom_range(0, 7) == 0) tgt = 32'hFFFF_FFF0 | (tgt & 32'hF);
            applyStimulus(rs, rt, tgt, rr);
        end
        checkOutput("rand_progress", 32'(consumed > 100), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
